// File: rtl/umem_bank_arbiter_if.sv
// rtl/umem_bank_arbiter_if.sv - requester and memory-side signal bundle for umem_bank_arbiter
interface umem_bank_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_bank;
    logic [NREQ-1:0]       req_we;
    logic [WIDTH*NREQ-1:0] req_addr;
    logic [WIDTH*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_err;
    logic [WIDTH*NREQ-1:0] rsp_rdata;
    logic [3:0]            mem_we;
    logic [4*WIDTH-1:0]    mem_a;
    logic [4*WIDTH-1:0]    mem_wd;
    logic [4*WIDTH-1:0]    mem_rd;

    modport slave (
        input  req_valid, req_bank, req_we, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_bank, req_we, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/umem_bank_arbiter.sv
// rtl/umem_bank_arbiter.sv - per-bank round-robin arbiter onto the four memory banks
// Optional UMEM_ARB_STATS_EN adds per-bank saturating grant/conflict counters.
module umem_bank_arbiter #(
    parameter int WIDTH  = 32,
    parameter int NREQ   = 4,
    parameter int DEPTH0 = 1024,
    parameter int DEPTH1 = 32,
    parameter int DEPTH2 = 1024,
    parameter int DEPTH3 = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    umem_bank_arbiter_if.slave bus
`ifdef UMEM_ARB_STATS_EN
    ,
    output logic [4*16-1:0]   stat_grants,
    output logic [4*16-1:0]   stat_conflicts
`endif
);
    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int B2_BITS = 5;

    function automatic logic [WIDTH:0] depth_of(input int b);
        case (b)
            0:       return (WIDTH+1)'(DEPTH0);
            1:       return (WIDTH+1)'(DEPTH1);
            2:       return (WIDTH+1)'(DEPTH2);
            default: return (WIDTH+1)'(DEPTH3);
        endcase
    endfunction

    logic [1:0]       bank_of  [NREQ];
    logic [WIDTH-1:0] addr_of  [NREQ];
    logic [WIDTH-1:0] wdata_of [NREQ];
    logic [PW-1:0]    rr_ptr   [4];
    logic [PW-1:0]    gnt_idx  [4];
    logic [3:0]       gnt_vld;
    logic [3:0]       gnt_oor;
    logic [3:0]       multi_cand;
    logic [WIDTH-1:0] rd_ext   [4];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bank_of[i]  = bus.req_bank[2*i +: 2];
            addr_of[i]  = bus.req_addr[WIDTH*i +: WIDTH];
            wdata_of[i] = bus.req_wdata[WIDTH*i +: WIDTH];
        end
    end

    // Scan upward from rr_ptr; the first matching requester wins the bank.
    always_comb begin
        int            sum;
        int            cnt;
        logic          found;
        logic [PW-1:0] idx;
        gnt_vld    = '0;
        gnt_oor    = '0;
        multi_cand = '0;
        for (int b = 0; b < 4; b++) begin
            gnt_idx[b] = '0;
            cnt        = 0;
            found      = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                sum = int'(rr_ptr[b]) + k;
                if (sum >= NREQ) sum = sum - NREQ;
                idx = PW'(sum);
                if (bus.req_valid[idx] && bank_of[idx] == 2'(b)) begin
                    cnt = cnt + 1;
                    if (!found) begin
                        found      = 1'b1;
                        gnt_idx[b] = idx;
                    end
                end
            end
            gnt_vld[b]    = found & rst_n;
            gnt_oor[b]    = {1'b0, addr_of[gnt_idx[b]]} >= depth_of(b);
            multi_cand[b] = (cnt >= 2);
        end
    end

    always_comb begin
        bus.mem_we = '0;
        bus.mem_a  = '0;
        bus.mem_wd = '0;
        for (int b = 0; b < 4; b++) begin
            if (gnt_vld[b]) begin
                bus.mem_a[b*WIDTH +: WIDTH]  = addr_of[gnt_idx[b]];
                bus.mem_wd[b*WIDTH +: WIDTH] = wdata_of[gnt_idx[b]];
                bus.mem_we[b]                = bus.req_we[gnt_idx[b]] & ~gnt_oor[b];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld[bank_of[i]] && gnt_idx[bank_of[i]] == PW'(i))
                bus.req_ready[i] = 1'b1;
        end
    end

    // Bank 2 holds only 5 significant bits; upper read bits are not trusted.
    logic unused_b2_hi;
    assign unused_b2_hi = ^bus.mem_rd[2*WIDTH+B2_BITS +: WIDTH-B2_BITS];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            if (b == 2)
                rd_ext[b] = {{(WIDTH-B2_BITS){1'b0}}, bus.mem_rd[b*WIDTH +: B2_BITS]};
            else
                rd_ext[b] = bus.mem_rd[b*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) rr_ptr[b] <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_err   <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (gnt_vld[b])
                    rr_ptr[b] <= (gnt_idx[b] == PW'(NREQ-1)) ? '0 : gnt_idx[b] + PW'(1);
            end
            for (int i = 0; i < NREQ; i++) begin
                bus.rsp_valid[i] <= bus.req_ready[i];
                bus.rsp_err[i]   <= bus.req_ready[i] & gnt_oor[bank_of[i]];
                if (bus.req_ready[i] && !bus.req_we[i] && !gnt_oor[bank_of[i]])
                    bus.rsp_rdata[WIDTH*i +: WIDTH] <= rd_ext[bank_of[i]];
                else
                    bus.rsp_rdata[WIDTH*i +: WIDTH] <= '0;
            end
        end
    end

`ifdef UMEM_ARB_STATS_EN
    logic [15:0] grants_q [4];
    logic [15:0] confl_q  [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                grants_q[b] <= '0;
                confl_q[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (gnt_vld[b] && grants_q[b] != 16'hFFFF)
                    grants_q[b] <= grants_q[b] + 16'd1;
                if (multi_cand[b] && confl_q[b] != 16'hFFFF)
                    confl_q[b] <= confl_q[b] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            stat_grants[b*16 +: 16]    = grants_q[b];
            stat_conflicts[b*16 +: 16] = confl_q[b];
        end
    end
`else
    logic unused_multi;
    assign unused_multi = ^multi_cand;
`endif
endmodule

// File: tb/tb_umem_bank_arbiter.sv
// tb/tb_umem_bank_arbiter.sv - directed and randomized checks of umem_bank_arbiter against a behavioural model
module tb_umem_bank_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    umem_bank_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

`ifdef UMEM_ARB_STATS_EN
    logic [63:0] stat_grants;
    logic [63:0] stat_conflicts;
`endif

    umem_bank_arbiter #(
        .WIDTH(W), .NREQ(N), .DEPTH0(1024), .DEPTH1(32), .DEPTH2(1024), .DEPTH3(512)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef UMEM_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic int dep(input int b);
        case (b)
            0:       return 1024;
            1:       return 32;
            2:       return 1024;
            default: return 512;
        endcase
    endfunction

    logic [31:0] mem    [4][1024];
    logic [31:0] shadow [4][1024];

    // Memory model: bank 2 keeps 5 bits and returns junk in the upper bits.
    always_comb begin
        logic [31:0] a;
        for (int b = 0; b < 4; b++) begin
            a = bus.mem_a[b*32 +: 32];
            if (a >= 32'(dep(b)))
                bus.mem_rd[b*32 +: 32] = 32'h0;
            else if (b == 2)
                bus.mem_rd[b*32 +: 32] = {27'h2AAAAAA, mem[b][a[9:0]][4:0]};
            else
                bus.mem_rd[b*32 +: 32] = mem[b][a[9:0]];
        end
    end

    logic [N-1:0] v;
    logic [N-1:0] we;
    logic [1:0]   bk [N];
    logic [31:0]  ad [N];
    logic [31:0]  wd [N];
    int           mptr [4];

    logic [N-1:0]   e_ready;
    logic [N-1:0]   e_err;
    logic [3:0]     e_we;
    logic [127:0]   e_a;
    logic [127:0]   e_wd;
    logic [N*W-1:0] e_rd;

    task automatic apply();
        bus.req_valid = v;
        bus.req_we    = we;
        for (int i = 0; i < N; i++) begin
            bus.req_bank[2*i +: 2]  = bk[i];
            bus.req_addr[W*i +: W]  = ad[i];
            bus.req_wdata[W*i +: W] = wd[i];
        end
    endtask

    task automatic tick();
        logic [3:0]   cw;
        logic [127:0] ca;
        logic [127:0] cd;
        cw = bus.mem_we;
        ca = bus.mem_a;
        cd = bus.mem_wd;
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++)
            if (cw[b]) mem[b][ca[b*32 +: 10]] = (b == 2) ? {27'h0, cd[b*32 +: 5]} : cd[b*32 +: 32];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v     = '0;
        apply();
        for (int b = 0; b < 4; b++) mptr[b] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Winner per bank = valid candidate at the smallest rotated distance from the pointer.
    task automatic model_cycle();
        int best, bd, d;
        logic oor;
        e_ready = '0; e_err = '0; e_we = '0; e_a = '0; e_wd = '0; e_rd = '0;
        for (int b = 0; b < 4; b++) begin
            best = -1;
            bd   = N;
            for (int i = 0; i < N; i++) begin
                if (v[i] && int'(bk[i]) == b) begin
                    d = (i - mptr[b] + N) % N;
                    if (d < bd) begin
                        bd   = d;
                        best = i;
                    end
                end
            end
            if (best >= 0) begin
                oor                = ad[best] >= 32'(dep(b));
                e_ready[best]      = 1'b1;
                e_err[best]        = oor;
                e_a[b*32 +: 32]    = ad[best];
                e_wd[b*32 +: 32]   = wd[best];
                if (!we[best] && !oor) e_rd[best*W +: W] = shadow[b][ad[best][9:0]];
                if (we[best] && !oor) begin
                    e_we[b] = 1'b1;
                    shadow[b][ad[best][9:0]] = (b == 2) ? (wd[best] & 32'h1F) : wd[best];
                end
                mptr[b] = (best + 1) % N;
            end
        end
    endtask

    task automatic test_reset();
        v = '1;
        for (int i = 0; i < N; i++) begin
            bk[i] = 2'(i); we[i] = 1'b1; ad[i] = 32'(i); wd[i] = $urandom;
        end
        apply();
        #2;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
        total++; if (bus.mem_we !== 4'b0000) begin bad++; $display("FAIL rst_mem_we got=%b exp=0000", bus.mem_we); end
        total++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_err !== 4'b0000) begin bad++; $display("FAIL rst_rsp valid=%b err=%b exp=0", bus.rsp_valid, bus.rsp_err); end
        total++; if (bus.rsp_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.rsp_rdata); end
        do_reset();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0000 || bus.mem_we !== 4'b0000) begin bad++; $display("FAIL idle_ready_we ready=%b we=%b exp=0", bus.req_ready, bus.mem_we); end
        total++; if (bus.mem_a !== '0 || bus.mem_wd !== '0) begin bad++; $display("FAIL idle_mem a=%h wd=%h exp=0", bus.mem_a, bus.mem_wd); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL idle_rsp got=%b exp=0000", bus.rsp_valid); end
    endtask

    task automatic test_single_read();
        do_reset();
        mem[1][5] = 32'hAB; shadow[1][5] = 32'hAB;
        v = 4'b0001; bk[0] = 2'd1; we[0] = 1'b0; ad[0] = 32'd5;
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL sr_ready got=%b exp=0001", bus.req_ready); end
        tick();
        v = '0; apply();
        total++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 4'b0000) begin bad++; $display("FAIL sr_rsp valid=%b err=%b exp=0001/0000", bus.rsp_valid, bus.rsp_err); end
        total++; if (bus.rsp_rdata[31:0] !== 32'hAB) begin bad++; $display("FAIL sr_rdata got=%h exp=000000ab", bus.rsp_rdata[31:0]); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL sr_rsp_drop got=%b exp=0000", bus.rsp_valid); end
    endtask

    task automatic test_contention();
        logic [31:0] da, db;
        da = $urandom; db = $urandom;
        do_reset();
        v = 4'b0101;
        bk[0] = 2'd0; we[0] = 1'b1; ad[0] = 32'd10; wd[0] = da;
        bk[2] = 2'd0; we[2] = 1'b1; ad[2] = 32'd10; wd[2] = db;
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0001 || bus.mem_we !== 4'b0001) begin bad++; $display("FAIL ct_c0 ready=%b we=%b exp=0001/0001", bus.req_ready, bus.mem_we); end
        total++; if (bus.mem_a[31:0] !== 32'd10 || bus.mem_wd[31:0] !== da) begin bad++; $display("FAIL ct_c0_bus a=%h wd=%h exp=a/%h", bus.mem_a[31:0], bus.mem_wd[31:0], da); end
        tick();
        v = 4'b0100; apply();
        total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL ct_rsp0 got=%b exp=0001", bus.rsp_valid); end
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0100 || bus.mem_wd[31:0] !== db) begin bad++; $display("FAIL ct_c1 ready=%b wd=%h exp=0100/%h", bus.req_ready, bus.mem_wd[31:0], db); end
        tick();
        v = 4'b0010; bk[1] = 2'd0; we[1] = 1'b0; ad[1] = 32'd10; apply();
        shadow[0][10] = db;
        total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL ct_rsp2 got=%b exp=0100", bus.rsp_valid); end
        @(negedge clk);
        tick();
        v = '0; apply();
        total++; if (bus.rsp_rdata[63:32] !== db) begin bad++; $display("FAIL ct_readback got=%h exp=%h", bus.rsp_rdata[63:32], db); end
    endtask

    task automatic test_parallel();
        logic [31:0] exp;
        do_reset();
        v = '1;
        for (int i = 0; i < N; i++) begin
            bk[i] = 2'(i); we[i] = 1'b1; ad[i] = 32'(i + 3); wd[i] = $urandom;
            shadow[i][i+3] = (i == 2) ? (wd[i] & 32'h1F) : wd[i];
        end
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b1111 || bus.mem_we !== 4'b1111) begin bad++; $display("FAIL par_w ready=%b we=%b exp=1111/1111", bus.req_ready, bus.mem_we); end
        tick();
        we = '0; apply();
        total++; if (bus.rsp_valid !== 4'b1111 || bus.rsp_err !== 4'b0000 || bus.rsp_rdata !== '0) begin bad++; $display("FAIL par_wack valid=%b err=%b rdata=%h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b1111 || bus.mem_we !== 4'b0000) begin bad++; $display("FAIL par_r ready=%b we=%b exp=1111/0000", bus.req_ready, bus.mem_we); end
        tick();
        v = '0; apply();
        for (int i = 0; i < N; i++) begin
            exp = shadow[i][i+3];
            total++; if (bus.rsp_rdata[W*i +: W] !== exp) begin bad++; $display("FAIL par_rdata%0d got=%h exp=%h", i, bus.rsp_rdata[W*i +: W], exp); end
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        v = 4'b0010; bk[1] = 2'd1; we[1] = 1'b1; ad[1] = 32'd40; wd[1] = $urandom;
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0010 || bus.mem_we !== 4'b0000) begin bad++; $display("FAIL oor_w ready=%b we=%b exp=0010/0000", bus.req_ready, bus.mem_we); end
        tick();
        v = '0; apply();
        total++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_err !== 4'b0010) begin bad++; $display("FAIL oor_rsp valid=%b err=%b exp=0010/0010", bus.rsp_valid, bus.rsp_err); end
        v = 4'b1011;
        bk[0] = 2'd0; we[0] = 1'b0; ad[0] = 32'd1023;
        bk[1] = 2'd1; we[1] = 1'b0; ad[1] = 32'd8;
        bk[3] = 2'd3; we[3] = 1'b0; ad[3] = 32'd512;
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b1011) begin bad++; $display("FAIL oor_rready got=%b exp=1011", bus.req_ready); end
        tick();
        v = '0; apply();
        total++; if (bus.rsp_err !== 4'b1000) begin bad++; $display("FAIL oor_rerr got=%b exp=1000", bus.rsp_err); end
        total++; if (bus.rsp_rdata[31:0] !== shadow[0][1023]) begin bad++; $display("FAIL oor_edge got=%h exp=%h", bus.rsp_rdata[31:0], shadow[0][1023]); end
        total++; if (bus.rsp_rdata[63:32] !== shadow[1][8]) begin bad++; $display("FAIL oor_unchanged got=%h exp=%h", bus.rsp_rdata[63:32], shadow[1][8]); end
        total++; if (bus.rsp_rdata[127:96] !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", bus.rsp_rdata[127:96]); end
    endtask

    task automatic test_round_robin();
        do_reset();
        v = '1;
        for (int i = 0; i < N; i++) begin
            bk[i] = 2'd3; we[i] = 1'b0; ad[i] = 32'(i);
        end
        apply();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++; if (bus.req_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_c%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % 4))); end
            tick();
        end
        v = '0; apply();
`ifdef UMEM_ARB_STATS_EN
        total++; if (stat_grants[63:48] !== 16'd8) begin bad++; $display("FAIL rr_grants got=%0d exp=8", stat_grants[63:48]); end
        total++; if (stat_conflicts[63:48] !== 16'd8) begin bad++; $display("FAIL rr_conflicts got=%0d exp=8", stat_conflicts[63:48]); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d0;
        d0 = $urandom;
        do_reset();
        v = 4'b0001; bk[0] = 2'd0; we[0] = 1'b1; ad[0] = 32'd20; wd[0] = d0;
        apply();
        @(negedge clk);
        tick();
        shadow[0][20] = d0;
        v = 4'b0010; bk[1] = 2'd0; we[1] = 1'b1; ad[1] = 32'd21; wd[1] = ~shadow[0][21];
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0010 || bus.mem_we !== 4'b0001) begin bad++; $display("FAIL rm_pre ready=%b we=%b exp=0010/0001", bus.req_ready, bus.mem_we); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0000 || bus.mem_we !== 4'b0000) begin bad++; $display("FAIL rm_comb ready=%b we=%b exp=0", bus.req_ready, bus.mem_we); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL rm_rsp got=%b exp=0000", bus.rsp_valid); end
        rst_n = 1'b1;
        for (int b = 0; b < 4; b++) mptr[b] = 0;
        v = 4'b0011; we[0] = 1'b0; we[1] = 1'b0;
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rm_ptr got=%b exp=0001", bus.req_ready); end
        tick();
        v = 4'b0010; apply();
        total++; if (bus.rsp_rdata[31:0] !== shadow[0][20]) begin bad++; $display("FAIL rm_rd20 got=%h exp=%h", bus.rsp_rdata[31:0], shadow[0][20]); end
        @(negedge clk);
        tick();
        v = '0; apply();
        total++; if (bus.rsp_rdata[63:32] !== shadow[0][21]) begin bad++; $display("FAIL rm_dropped got=%h exp=%h", bus.rsp_rdata[63:32], shadow[0][21]); end
    endtask

    task automatic test_random();
        logic [N-1:0]   p_rv;
        logic [N-1:0]   p_re;
        logic [N*W-1:0] p_rd;
        int             r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 3) != 0) begin
                    v[i]  = 1'b1;
                    bk[i] = 2'($urandom_range(0, 3));
                    we[i] = 1'($urandom_range(0, 1));
                    wd[i] = $urandom;
                    r     = $urandom_range(0, 9);
                    if (r == 0)      ad[i] = 32'(dep(int'(bk[i])) + $urandom_range(0, 2));
                    else if (r == 1) ad[i] = 32'(dep(int'(bk[i])) - 1);
                    else             ad[i] = 32'($urandom_range(0, (bk[i] == 2'd1) ? 31 : 15));
                end
            end
            apply();
            @(negedge clk);
            model_cycle();
            total++; if (bus.req_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready, e_ready); end
            total++; if (bus.mem_we !== e_we) begin bad++; $display("FAIL rnd_mem_we c=%0d got=%b exp=%b", c, bus.mem_we, e_we); end
            total++; if (bus.mem_a !== e_a || bus.mem_wd !== e_wd) begin bad++; $display("FAIL rnd_mem_bus c=%0d a=%h/%h wd=%h/%h", c, bus.mem_a, e_a, bus.mem_wd, e_wd); end
            p_rv = e_ready; p_re = e_err; p_rd = e_rd;
            tick();
            total++; if (bus.rsp_valid !== p_rv || bus.rsp_err !== p_re) begin bad++; $display("FAIL rnd_rsp c=%0d valid=%b/%b err=%b/%b", c, bus.rsp_valid, p_rv, bus.rsp_err, p_re); end
            total++; if (bus.rsp_rdata !== p_rd) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, bus.rsp_rdata, p_rd); end
            v = v & ~p_rv;
        end
        v = '0; apply();
    endtask

    initial begin
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 1024; a++) begin
                mem[b][a]    = (b == 2) ? ($urandom & 32'h1F) : $urandom;
                shadow[b][a] = mem[b][a];
            end
        v = '0; we = '0;
        for (int i = 0; i < N; i++) begin
            bk[i] = '0; ad[i] = '0; wd[i] = '0;
        end
        apply();
        test_reset();
        test_single_read();
        test_contention();
        test_parallel();
        test_out_of_range();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
